// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: PC+4 sequencing, stall hold, EX redirect with flush bubbles, sticky HALT.
// Optional branch statistics counters are built when BRANCH_STATS_EN is defined.
module fetch_pc_ctrl #(
    parameter int unsigned PC_W         = 9,
    parameter int unsigned RESET_PC     = 0,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            halt_req,
    output logic [PC_W-1:0] PC,
    output logic            if_valid,
    output logic            flush,
    output logic            halted,
    output logic            addr_err,
    output logic [15:0]     redirect_cnt,
    output logic [15:0]     bubble_cnt
);

    typedef enum logic [1:0] {StRun, StFlush, StHalted} state_e;

    localparam logic [1:0] CntInit = 2'(FLUSH_CYCLES - 1);

    state_e          state_q;
    logic [1:0]      cnt_q;
    logic            started_q;
    logic [PC_W-1:0] target;
    logic            target_bad;
    logic            accept;

    assign target     = {BrPC[PC_W-1:2], 2'b00};
    assign target_bad = (BrPC[1:0] != 2'b00) || ((BrPC >> PC_W) != 32'd0);
    // A redirect is honoured in RUN and FLUSH, never on the wake-up edge or once halted.
    assign accept     = started_q && PcSel && (state_q != StHalted);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StRun;
            cnt_q     <= 2'd0;
            started_q <= 1'b0;
            PC        <= PC_W'(RESET_PC);
            if_valid  <= 1'b0;
            flush     <= 1'b0;
            halted    <= 1'b0;
            addr_err  <= 1'b0;
        end else if (!started_q) begin
            started_q <= 1'b1;
            if_valid  <= 1'b1;
        end else begin
            if (accept && target_bad) addr_err <= 1'b1;
            case (state_q)
                StRun: begin
                    if (PcSel) begin
                        PC       <= target;
                        state_q  <= StFlush;
                        cnt_q    <= CntInit;
                        flush    <= 1'b1;
                        if_valid <= 1'b0;
                    end else if (halt_req) begin
                        state_q  <= StHalted;
                        halted   <= 1'b1;
                        if_valid <= 1'b0;
                    end else if (!stall) begin
                        PC       <= PC + PC_W'(4);
                        if_valid <= 1'b1;
                    end
                end
                StFlush: begin
                    if (PcSel) begin
                        PC    <= target;
                        cnt_q <= CntInit;
                    end else if (cnt_q == 2'd0) begin
                        state_q  <= StRun;
                        flush    <= 1'b0;
                        if_valid <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                StHalted: begin
                end
                default: state_q <= StRun;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating counters; bubbles are counted on each edge that closes a flush cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_cnt <= 16'd0;
            bubble_cnt   <= 16'd0;
        end else begin
            if (accept && (redirect_cnt != 16'hFFFF)) redirect_cnt <= redirect_cnt + 16'd1;
            if (flush && (bubble_cnt != 16'hFFFF)) bubble_cnt <= bubble_cnt + 16'd1;
        end
    end
`else
    assign redirect_cnt = 16'd0;
    assign bubble_cnt   = 16'd0;
`endif

endmodule
